id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised, registered instruction-decode stage for the 5-stage MIPS-subset core, placed between IF/ID and EX.
- Decodes one instruction per cycle, reads the register file combinationally, and resolves operands with EX/MEM forwarding.
- Detects load-use hazards and inserts bubbles.
- Holds its result in an internal ID/EX register with a valid/ready handshake, so back-pressure from EX stalls fetch cleanly.

Parameters:
- DATA_W, 32, operand/register data width.
- REG_AW, 5, register address width.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- if_valid_i  in  1  pc_i/inst_i valid.
- if_ready_o  out  1  stage accepts the instruction this cycle.
- pc_i  in  PC_W  instruction address.
- inst_i  in  32  instruction word.
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational).
- reg1_addr_o, reg2_addr_o  out  REG_AW  regfile read addresses (combinational).
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data, same cycle.
- ex_wreg_i, ex_wd_i, ex_wdata_i  in  1/REG_AW/DATA_W  EX-stage pending write.
- ex_is_load_i  in  1  EX-stage instruction is a load (data not yet available).
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage pending write.
- flush_i  in  1  squash the held and the incoming instruction.
- ex_valid_o  out  1  ID/EX register holds a valid instruction.
- ex_ready_i  in  1  EX consumes it this cycle.
- aluop_o  out  8  ALU operation (defines.v encoding).
- alusel_o  out  3  result select.
- reg1_o, reg2_o  out  DATA_W  resolved operands.
- wd_o  out  REG_AW  destination register.
- wreg_o  out  1  write enable.
- pc_o  out  PC_W  pc of the held instruction.
- inst_invalid_o  out  1  held instruction is not a supported encoding.

Behaviour:
- Reset (async, rst=1): ex_valid_o=0; all registered outputs zero (aluop NOP, alusel NOP, wd_o=0, wreg_o=0, pc_o=0, inst_invalid_o=0).
- Supported instructions:
  - ORI/ANDI/XORI: reg2 = zero-extended imm16, wd=rt.
  - LUI: reg1 = 0 (no read), reg2 = {imm16,16'h0}, aluop OR, wd=rt.
  - SPECIAL AND/OR/XOR/NOR: reg1=rs, reg2=rt, wd=rd.
  - SLL/SRL/SRA: reg1 = zero-extended sa, reg2=rt, wd=rd.
  - All-zero word: NOP with wreg=0.
  - Anything else: wreg=0, aluop NOP, inst_invalid_o=1.
- Operand priority per source with read enable set: address 0 gives 0; else EX write if ex_wreg_i and address match; else MEM write on match; else regfile data.
- load_use = if_valid_i & ex_is_load_i & ex_wreg_i & ex_wd_i!=0 & (any enabled read address == ex_wd_i).
- if_ready_o = (!ex_valid_o | ex_ready_i) & !load_use, or 1 when flush_i.
- Each rising clk, in priority order:
  - flush_i: ex_valid_o<=0 and the input is dropped.
  - else if if_valid_i & if_ready_o: capture the decoded instruction, ex_valid_o<=1.
  - else if ex_ready_i: ex_valid_o<=0 (bubble).
  - else: hold all outputs unchanged.
- Latency is one cycle from acceptance to ex_valid_o.
- While ex_valid_o=1 and ex_ready_i=0, outputs are stable.
- Load-use inserts exactly one bubble when EX advances.
- When ex_valid_o=0, wreg_o must read 0.

Optional Feature:
- ID_FWD_EN defined: forwarding as above.
- ID_FWD_EN undefined:
  - Forwarding muxes are removed; operands come from the regfile or the immediate only.
  - Any enabled read matching a non-zero EX or MEM pending write deasserts if_ready_o (RAW stall); bubbles are inserted until the match clears.
  - load_use is subsumed by the RAW stall.

Decomposition:
- Opcodes, funct codes, aluop/alusel encodings, ZeroWord, NOPRegAddr, and RstEnable live in the shared defines.v.
- Sub-module id_decode: purely combinational inst_i to {aluop, alusel, wd, wreg, read enables, addresses, imm, invalid}.
- id_stage_pipe adds the operand resolution, hazard logic, and ID/EX register.

Test Plan:
- ORI $2,$1,0x00FF with regfile $1=0x12340000 and no hazards → next cycle ex_valid_o=1, aluop OR, reg1_o=0x12340000, reg2_o=0x000000FF, wd_o=2, wreg_o=1.
- OR $3,$1,$2 with ex_wd_i=1, ex_wdata_i=0xAAAA0000 and mem_wd_i=1, mem_wdata_i=0x5 → reg1_o=0xAAAA0000 (EX wins). Without ID_FWD_EN: if_ready_o=0 until the hazard clears.
- Load in EX writing $4 (ex_is_load_i=1), ANDI $5,$4,1 presented → if_ready_o=0 for one cycle, one bubble (ex_valid_o=0), then accepted with MEM-forwarded data.
- ex_ready_i=0 for 3 cycles with a valid held instruction and a new one offered → outputs stable, if_ready_o=0; the new instruction is captured on the cycle ex_ready_i=1.
- flush_i with a valid held instruction and if_valid_i=1 → next cycle ex_valid_o=0 and the incoming instruction is dropped. Assert rst mid-stall → all outputs zero immediately.
- inst_i=0xFC000000 → inst_invalid_o=1, wreg_o=0. SLL $6,$7,4 → reg1_o=4, reg2_o=$7.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_pkg
// Purpose  : Shared encodings for the ID stage of the MIPS-subset core.
//            Holds the opcodes, funct codes, ALU operation / result-select
//            codes, the zero word, the NOP register address, the reset level
//            and the instruction-class enum used by the decoder.
// Revision : 1.0 - initial release
// ============================================================================
package id_stage_pipe_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
  localparam logic [5:0] c_OP_ANDI    = 6'b001100;
  localparam logic [5:0] c_OP_ORI     = 6'b001101;
  localparam logic [5:0] c_OP_XORI    = 6'b001110;
  localparam logic [5:0] c_OP_LUI     = 6'b001111;

  // SPECIAL funct codes (inst[5:0])
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_XOR = 6'b100110;
  localparam logic [5:0] c_FN_NOR = 6'b100111;
  localparam logic [5:0] c_FN_SLL = 6'b000000;
  localparam logic [5:0] c_FN_SRL = 6'b000010;
  localparam logic [5:0] c_FN_SRA = 6'b000011;

  // ALU operation codes
  localparam logic [7:0] c_ALUOP_NOP = 8'b00000000;
  localparam logic [7:0] c_ALUOP_AND = 8'b00100100;
  localparam logic [7:0] c_ALUOP_OR  = 8'b00100101;
  localparam logic [7:0] c_ALUOP_XOR = 8'b00100110;
  localparam logic [7:0] c_ALUOP_NOR = 8'b00100111;
  localparam logic [7:0] c_ALUOP_SLL = 8'b01111100;
  localparam logic [7:0] c_ALUOP_SRL = 8'b00000010;
  localparam logic [7:0] c_ALUOP_SRA = 8'b00000011;

  // Result-select codes
  localparam logic [2:0] c_ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] c_ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] c_ALUSEL_SHIFT = 3'b010;

  localparam logic [31:0] c_ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  c_NOP_REG_ADDR = 5'b00000;
  localparam logic        c_RST_ENABLE   = 1'b1;

  // Instruction classes recognised by the decoder
  typedef enum logic [2:0] {
    CLS_NOP       = 3'd0,
    CLS_IMM_LOGIC = 3'd1,
    CLS_LUI       = 3'd2,
    CLS_R_LOGIC   = 3'd3,
    CLS_SHIFT     = 3'd4,
    CLS_INVALID   = 3'd5
  } inst_class_e;

endpackage : id_stage_pipe_pkg
`default_nettype wire

// File: rtl/id_stage_pipe_decode.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_decode
// Purpose  : Purely combinational instruction decoder. Maps an instruction
//            word to ALU op / result select, destination, register-file read
//            enables and addresses, and the immediate operands used when a
//            read port is not enabled.
// Ports    : i_inst                 - instruction word
//            o_aluop, o_alusel      - ALU operation and result select
//            o_wd, o_wreg           - destination register and write enable
//            o_reg{1,2}_read/addr   - register-file read enables/addresses
//            o_imm1, o_imm2         - operand value when the port is unread
//            o_invalid              - unsupported encoding
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_pipe_decode
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       i_inst,
  output logic [7:0]        o_aluop,
  output logic [2:0]        o_alusel,
  output logic [REG_AW-1:0] o_wd,
  output logic              o_wreg,
  output logic              o_reg1_read,
  output logic              o_reg2_read,
  output logic [REG_AW-1:0] o_reg1_addr,
  output logic [REG_AW-1:0] o_reg2_addr,
  output logic [DATA_W-1:0] o_imm1,
  output logic [DATA_W-1:0] o_imm2,
  output logic              o_invalid
);

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sa;
  logic [15:0] w_imm16;
  inst_class_e w_cls;

  assign w_op    = i_inst[31:26];
  assign w_rs    = i_inst[25:21];
  assign w_rt    = i_inst[20:16];
  assign w_rd    = i_inst[15:11];
  assign w_sa    = i_inst[10:6];
  assign w_fn    = i_inst[5:0];
  assign w_imm16 = i_inst[15:0];

  // The all-zero word is SLL $0,$0,0 by encoding; it is singled out so it
  // decodes as a true NOP with no register write.
  always_comb begin
    w_cls = CLS_INVALID;
    if (i_inst == c_ZERO_WORD) begin
      w_cls = CLS_NOP;
    end else begin
      case (w_op)
        c_OP_ANDI, c_OP_ORI, c_OP_XORI: w_cls = CLS_IMM_LOGIC;
        c_OP_LUI:                       w_cls = CLS_LUI;
        c_OP_SPECIAL: begin
          case (w_fn)
            c_FN_AND, c_FN_OR, c_FN_XOR, c_FN_NOR: w_cls = CLS_R_LOGIC;
            c_FN_SLL, c_FN_SRL, c_FN_SRA:          w_cls = CLS_SHIFT;
            default:                               w_cls = CLS_INVALID;
          endcase
        end
        default: w_cls = CLS_INVALID;
      endcase
    end
  end

  always_comb begin
    o_aluop     = c_ALUOP_NOP;
    o_alusel    = c_ALUSEL_NOP;
    o_wd        = REG_AW'(c_NOP_REG_ADDR);
    o_wreg      = 1'b0;
    o_reg1_read = 1'b0;
    o_reg2_read = 1'b0;
    o_reg1_addr = REG_AW'(w_rs);
    o_reg2_addr = REG_AW'(w_rt);
    o_imm1      = '0;
    o_imm2      = '0;
    o_invalid   = 1'b0;
    case (w_cls)
      CLS_IMM_LOGIC: begin
        o_alusel    = c_ALUSEL_LOGIC;
        o_wd        = REG_AW'(w_rt);
        o_wreg      = 1'b1;
        o_reg1_read = 1'b1;
        o_imm2      = DATA_W'(w_imm16);
        case (w_op)
          c_OP_ANDI: o_aluop = c_ALUOP_AND;
          c_OP_ORI:  o_aluop = c_ALUOP_OR;
          default:   o_aluop = c_ALUOP_XOR;
        endcase
      end
      CLS_LUI: begin
        // LUI is executed as 0 | {imm,16'h0}
        o_aluop  = c_ALUOP_OR;
        o_alusel = c_ALUSEL_LOGIC;
        o_wd     = REG_AW'(w_rt);
        o_wreg   = 1'b1;
        o_imm2   = DATA_W'({w_imm16, 16'h0000});
      end
      CLS_R_LOGIC: begin
        o_alusel    = c_ALUSEL_LOGIC;
        o_wd        = REG_AW'(w_rd);
        o_wreg      = 1'b1;
        o_reg1_read = 1'b1;
        o_reg2_read = 1'b1;
        case (w_fn)
          c_FN_AND: o_aluop = c_ALUOP_AND;
          c_FN_OR:  o_aluop = c_ALUOP_OR;
          c_FN_XOR: o_aluop = c_ALUOP_XOR;
          default:  o_aluop = c_ALUOP_NOR;
        endcase
      end
      CLS_SHIFT: begin
        // Shift amount travels on operand 1, the shifted value on operand 2
        o_alusel    = c_ALUSEL_SHIFT;
        o_wd        = REG_AW'(w_rd);
        o_wreg      = 1'b1;
        o_reg2_read = 1'b1;
        o_imm1      = DATA_W'(w_sa);
        case (w_fn)
          c_FN_SLL: o_aluop = c_ALUOP_SLL;
          c_FN_SRL: o_aluop = c_ALUOP_SRL;
          default:  o_aluop = c_ALUOP_SRA;
        endcase
      end
      CLS_INVALID: o_invalid = 1'b1;
      default: ;
    endcase
  end

endmodule : id_stage_pipe_decode
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : Registered instruction-decode stage between IF/ID and EX.
//            Decodes one instruction per cycle, reads the register file
//            combinationally, resolves operands, detects data hazards and
//            holds the result in an ID/EX register with a valid/ready
//            handshake.
// Config   : ID_FWD_EN defined   - EX/MEM forwarding, stall on load-use only.
//            ID_FWD_EN undefined - no forwarding; any enabled read that
//                                  matches a pending EX/MEM write stalls.
// Ports    : if_valid_i/if_ready_o, pc_i, inst_i - fetch side handshake
//            reg{1,2}_read_o/addr_o/data_i       - register-file read ports
//            ex_*/mem_* inputs                   - pending EX/MEM writes
//            flush_i                             - squash held + incoming
//            ex_valid_o/ex_ready_i               - EX side handshake
//            aluop_o..inst_invalid_o             - ID/EX register contents
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              inst_invalid_o
);

  logic [7:0]        w_aluop;
  logic [2:0]        w_alusel;
  logic [REG_AW-1:0] w_wd;
  logic              w_wreg;
  logic              w_r1e;
  logic              w_r2e;
  logic [REG_AW-1:0] w_a1;
  logic [REG_AW-1:0] w_a2;
  logic [DATA_W-1:0] w_imm1;
  logic [DATA_W-1:0] w_imm2;
  logic              w_invalid;

  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic              w_hit_ex;
  logic              w_hit_mem;
  logic              w_stall;
  logic              w_ready;

  logic              r_valid;
  logic [7:0]        r_aluop;
  logic [2:0]        r_alusel;
  logic [DATA_W-1:0] r_reg1;
  logic [DATA_W-1:0] r_reg2;
  logic [REG_AW-1:0] r_wd;
  logic              r_wreg;
  logic [PC_W-1:0]   r_pc;
  logic              r_invalid;

  id_stage_pipe_decode #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_decode (
    .i_inst      (inst_i),
    .o_aluop     (w_aluop),
    .o_alusel    (w_alusel),
    .o_wd        (w_wd),
    .o_wreg      (w_wreg),
    .o_reg1_read (w_r1e),
    .o_reg2_read (w_r2e),
    .o_reg1_addr (w_a1),
    .o_reg2_addr (w_a2),
    .o_imm1      (w_imm1),
    .o_imm2      (w_imm2),
    .o_invalid   (w_invalid)
  );

  assign reg1_read_o = w_r1e;
  assign reg2_read_o = w_r2e;
  assign reg1_addr_o = w_a1;
  assign reg2_addr_o = w_a2;

  // A pending write to $0 never creates a dependency.
  assign w_hit_ex  = ex_wreg_i & (ex_wd_i != '0) &
                     ((w_r1e & (w_a1 == ex_wd_i)) | (w_r2e & (w_a2 == ex_wd_i)));
  assign w_hit_mem = mem_wreg_i & (mem_wd_i != '0) &
                     ((w_r1e & (w_a1 == mem_wd_i)) | (w_r2e & (w_a2 == mem_wd_i)));

`ifdef ID_FWD_EN
  // Youngest producer (EX) wins over MEM, which wins over the regfile.
  function automatic logic [DATA_W-1:0] f_operand(
    input logic              en,
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] imm,
    input logic              ex_we,
    input logic [REG_AW-1:0] ex_wa,
    input logic [DATA_W-1:0] ex_wdat,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_wa,
    input logic [DATA_W-1:0] mem_wdat
  );
    logic [DATA_W-1:0] v;
    if (!en)                           v = imm;
    else if (addr == '0)               v = '0;
    else if (ex_we && ex_wa == addr)   v = ex_wdat;
    else if (mem_we && mem_wa == addr) v = mem_wdat;
    else                               v = rf_data;
    return v;
  endfunction

  assign w_op1 = f_operand(w_r1e, w_a1, reg1_data_i, w_imm1, ex_wreg_i, ex_wd_i,
                           ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign w_op2 = f_operand(w_r2e, w_a2, reg2_data_i, w_imm2, ex_wreg_i, ex_wd_i,
                           ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);

  // Only a load in EX cannot be forwarded yet; its data shows up in MEM.
  assign w_stall = if_valid_i & ex_is_load_i & w_hit_ex;

  logic w_unused_mem_hit;
  assign w_unused_mem_hit = w_hit_mem;
`else
  assign w_op1 = !w_r1e ? w_imm1 : (w_a1 == '0) ? '0 : reg1_data_i;
  assign w_op2 = !w_r2e ? w_imm2 : (w_a2 == '0) ? '0 : reg2_data_i;

  // Without forwarding every pending EX/MEM write to a source is a RAW stall;
  // this also covers the load-use case.
  assign w_stall = if_valid_i & (w_hit_ex | w_hit_mem);

  logic w_unused_nofwd;
  assign w_unused_nofwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

  // A flush empties the stage, so the fetch side may always advance.
  assign w_ready    = flush_i | ((~r_valid | ex_ready_i) & ~w_stall);
  assign if_ready_o = w_ready;

  // wreg is cleared whenever the register empties so a bubble never writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == c_RST_ENABLE) begin
      r_valid   <= 1'b0;
      r_aluop   <= c_ALUOP_NOP;
      r_alusel  <= c_ALUSEL_NOP;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      r_pc      <= '0;
      r_invalid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
    end else if (if_valid_i & w_ready) begin
      r_valid   <= 1'b1;
      r_aluop   <= w_aluop;
      r_alusel  <= w_alusel;
      r_reg1    <= w_op1;
      r_reg2    <= w_op2;
      r_wd      <= w_wd;
      r_wreg    <= w_wreg;
      r_pc      <= pc_i;
      r_invalid <= w_invalid;
    end else if (ex_ready_i) begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
    end
  end

  assign ex_valid_o     = r_valid;
  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_o         = r_reg1;
  assign reg2_o         = r_reg2;
  assign wd_o           = r_wd;
  assign wreg_o         = r_wreg;
  assign pc_o           = r_pc;
  assign inst_invalid_o = r_invalid;

endmodule : id_stage_pipe
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipe
// Purpose  : Self-checking bench for id_stage_pipe. Acts as register file,
//            fetch and EX/MEM stages; compares the DUT against a behavioural
//            model of the decode stage. Follows ID_FWD_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i, if_ready_o;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, ex_valid_o, ex_ready_i;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, inst_invalid_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf [32];
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
    .ex_ready_i(ex_ready_i), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .pc_o(pc_o), .inst_invalid_o(inst_invalid_o)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic        r1e, r2e;
    logic [4:0]  a1, a2;
    logic [31:0] imm1, imm2;
    logic        inv;
  } dec_t;

  // Model state of the ID/EX register
  logic        m_valid, m_wreg, m_inv;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  logic [31:0] m_r1, m_r2, m_pc;
  logic [4:0]  m_wd;

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    d = '0;
    d.a1 = ins[25:21];
    d.a2 = ins[20:16];
    if (ins == 32'h0) return d;
    if (op == 6'h0c || op == 6'h0d || op == 6'h0e) begin
      d.aluop = (op == 6'h0c) ? 8'h24 : (op == 6'h0d) ? 8'h25 : 8'h26;
      d.alusel = 3'd1; d.wd = ins[20:16]; d.wreg = 1'b1; d.r1e = 1'b1;
      d.imm2 = {16'h0, ins[15:0]};
    end else if (op == 6'h0f) begin
      d.aluop = 8'h25; d.alusel = 3'd1; d.wd = ins[20:16]; d.wreg = 1'b1;
      d.imm2 = {ins[15:0], 16'h0};
    end else if (op == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
      d.aluop = {2'b00, fn}; d.alusel = 3'd1; d.wd = ins[15:11]; d.wreg = 1'b1;
      d.r1e = 1'b1; d.r2e = 1'b1;
    end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
      d.aluop = (fn == 6'h00) ? 8'h7c : {2'b00, fn};
      d.alusel = 3'd2; d.wd = ins[15:11]; d.wreg = 1'b1; d.r2e = 1'b1;
      d.imm1 = {27'h0, ins[10:6]};
    end else begin
      d.inv = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_operand(input logic en, input logic [4:0] a,
                                              input logic [31:0] imm);
    if (!en) return imm;
    if (a == 5'd0) return 32'h0;
`ifdef ID_FWD_EN
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
`endif
    return rf[a];
  endfunction

  function automatic logic ref_stall(input dec_t d);
    logic hx, hm;
    hx = ex_wreg_i && ex_wd_i != 0 && ((d.r1e && d.a1 == ex_wd_i) || (d.r2e && d.a2 == ex_wd_i));
    hm = mem_wreg_i && mem_wd_i != 0 && ((d.r1e && d.a1 == mem_wd_i) || (d.r2e && d.a2 == mem_wd_i));
`ifdef ID_FWD_EN
    return if_valid_i && ex_is_load_i && hx;
`else
    return if_valid_i && (hx || hm);
`endif
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_wreg = 0; m_inv = 0; m_aluop = 0; m_alusel = 0;
    m_r1 = 0; m_r2 = 0; m_pc = 0; m_wd = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, ex_valid_o, 0);
    chk({tag, "_wreg"}, wreg_o, 0);
    chk({tag, "_aluop"}, aluop_o, 0);
    chk({tag, "_alusel"}, alusel_o, 0);
    chk({tag, "_wd"}, wd_o, 0);
    chk({tag, "_pc"}, pc_o, 0);
    chk({tag, "_inv"}, inst_invalid_o, 0);
    chk({tag, "_reg1"}, reg1_o, 0);
    chk({tag, "_reg2"}, reg2_o, 0);
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic cycle();
    dec_t d;
    logic rdy;
    logic [31:0] n1, n2;
    #1;
    d   = ref_decode(inst_i);
    rdy = flush_i || ((!m_valid || ex_ready_i) && !ref_stall(d));
    chk("if_ready", if_ready_o, rdy);
    chk("rd1_en", reg1_read_o, d.r1e);
    chk("rd2_en", reg2_read_o, d.r2e);
    if (d.r1e) chk("rd1_addr", reg1_addr_o, d.a1);
    if (d.r2e) chk("rd2_addr", reg2_addr_o, d.a2);
    n1 = ref_operand(d.r1e, d.a1, d.imm1);
    n2 = ref_operand(d.r2e, d.a2, d.imm2);
    @(posedge clk);
    if (flush_i) begin
      m_valid = 0; m_wreg = 0;
    end else if (if_valid_i && rdy) begin
      m_valid = 1; m_aluop = d.aluop; m_alusel = d.alusel; m_r1 = n1; m_r2 = n2;
      m_wd = d.wd; m_wreg = d.wreg; m_pc = pc_i; m_inv = d.inv;
    end else if (ex_ready_i) begin
      m_valid = 0; m_wreg = 0;
    end
    #1;
    chk("ex_valid", ex_valid_o, m_valid);
    chk("wreg", wreg_o, m_wreg);
    if (m_valid) begin
      chk("aluop", aluop_o, m_aluop);
      chk("alusel", alusel_o, m_alusel);
      chk("reg1", reg1_o, m_r1);
      chk("reg2", reg2_o, m_r2);
      chk("wd", wd_o, m_wd);
      chk("pc", pc_o, m_pc);
      chk("inv", inst_invalid_o, m_inv);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    int k;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    sa = 5'($urandom);
    imm = 16'($urandom);
    k = $urandom_range(0, 2);
    case ($urandom_range(0, 9))
      0: return {6'h0c, rs, rt, imm};
      1: return {6'h0e, rs, rt, imm};
      2: return {6'h0f, 5'h0, rt, imm};
      3, 4: return {6'h00, rs, rt, rd, 5'h0, 6'(6'h24 + $urandom_range(0, 3))};
      5: return {6'h00, 5'h0, rt, rd, sa, (k == 0) ? 6'h00 : 6'(k + 1)};
      6: return 32'h0;
      7: return $urandom;
      default: return {6'h0d, rs, rt, imm};
    endcase
  endfunction

  task automatic quiet_hazards();
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;   // must never be seen through address 0
    rf[1] = 32'h1234_0000;
    rf[2] = 32'h0000_F00D;
    rf[7] = 32'h8765_4321;
    rst = 1; if_valid_i = 0; pc_i = 0; inst_i = 0; flush_i = 0; ex_ready_i = 1;
    quiet_hazards();
    model_reset();
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;

    // ORI $2,$1,0x00FF
    if_valid_i = 1; pc_i = 32'h100; inst_i = 32'h3422_00FF;
    cycle();
    chk("ori_valid", ex_valid_o, 1);
    chk("ori_aluop", aluop_o, 8'h25);
    chk("ori_reg1", reg1_o, 32'h1234_0000);
    chk("ori_reg2", reg2_o, 32'h0000_00FF);
    chk("ori_wd", wd_o, 2);
    chk("ori_wreg", wreg_o, 1);

    // OR $3,$1,$2 with EX and MEM both writing $1
    pc_i = 32'h104; inst_i = 32'h0022_1825;
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hAAAA_0000;
    mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'h5;
`ifdef ID_FWD_EN
    cycle();
    chk("fwd_ex_wins", reg1_o, 32'hAAAA_0000);
    chk("fwd_reg2", reg2_o, 32'h0000_F00D);
`else
    #1 chk("raw_stall", if_ready_o, 0);
    cycle();
    cycle();
    chk("raw_bubble", ex_valid_o, 0);
    quiet_hazards();
    cycle();
    chk("raw_cleared_reg1", reg1_o, 32'h1234_0000);
`endif
    quiet_hazards();

    // Load in EX writing $4, ANDI $5,$4,1 offered
    pc_i = 32'h108; inst_i = 32'h3085_0001;
    ex_wreg_i = 1; ex_wd_i = 4; ex_wdata_i = 32'h1111_1111; ex_is_load_i = 1;
    #1 chk("lu_stall", if_ready_o, 0);
    cycle();
    chk("lu_bubble", ex_valid_o, 0);
    quiet_hazards();
    mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h77;
`ifdef ID_FWD_EN
    #1 chk("lu_go", if_ready_o, 1);
    cycle();
    chk("lu_mem_fwd", reg1_o, 32'h77);
`else
    cycle();
    chk("lu_raw_bubble", ex_valid_o, 0);
    quiet_hazards();
    cycle();
    chk("lu_rf_reg1", reg1_o, rf[4]);
`endif
    chk("lu_wd", wd_o, 5);
    quiet_hazards();

    // Back-pressure: ANDI held, XORI $1,$2,0x0F0F offered
    ex_ready_i = 0; pc_i = 32'h10C; inst_i = 32'h3841_0F0F;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", if_ready_o, 0);
      cycle();
      chk("bp_hold_aluop", aluop_o, 8'h24);
      chk("bp_hold_pc", pc_o, 32'h108);
    end
    ex_ready_i = 1;
    cycle();
    chk("bp_capture_aluop", aluop_o, 8'h26);
    chk("bp_capture_pc", pc_o, 32'h10C);

    // Flush with held instruction and incoming one
    ex_ready_i = 0; flush_i = 1; pc_i = 32'h110; inst_i = 32'h3422_00FF;
    cycle();
    chk("flush_valid", ex_valid_o, 0);
    chk("flush_wreg", wreg_o, 0);
    flush_i = 0; if_valid_i = 0;
    cycle();
    chk("flush_dropped", ex_valid_o, 0);

    // Unsupported encoding, then SLL $6,$7,4
    if_valid_i = 1; ex_ready_i = 1; pc_i = 32'h114; inst_i = 32'hFC00_0000;
    cycle();
    chk("inv_flag", inst_invalid_o, 1);
    chk("inv_wreg", wreg_o, 0);
    pc_i = 32'h118; inst_i = 32'h0007_3100;
    cycle();
    chk("sll_reg1", reg1_o, 4);
    chk("sll_reg2", reg2_o, 32'h8765_4321);
    chk("sll_wd", wd_o, 6);

    // Reset while stalled
    ex_ready_i = 0; pc_i = 32'h11C; inst_i = 32'h3422_00FF;
    #2 rst = 1;
    #1 chk_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 0;

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if_valid_i   = ($urandom_range(0, 9) < 8);
      inst_i       = rand_inst();
      pc_i         = $urandom;
      ex_wreg_i    = 1'($urandom_range(0, 1));
      ex_wd_i      = 5'($urandom_range(0, 7));
      ex_wdata_i   = $urandom;
      ex_is_load_i = ($urandom_range(0, 3) == 0);
      mem_wreg_i   = 1'($urandom_range(0, 1));
      mem_wd_i     = 5'($urandom_range(0, 7));
      mem_wdata_i  = $urandom;
      flush_i      = ($urandom_range(0, 19) == 0);
      ex_ready_i   = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_id_stage_pipe
`default_nettype wire
